// File: rtl/sel_arb_32x4.sv
// Four-source packet arbiter feeding a 32x4 priority select and one output register.
// Optional round-robin priority rotation enabled by defining SEL_ARB_RR_EN.
module sel_arb_32x4 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       req_valid,
    input  logic [3:0]       req_last,
    input  logic [WIDTH-1:0] req_data0,
    input  logic [WIDTH-1:0] req_data1,
    input  logic [WIDTH-1:0] req_data2,
    input  logic [WIDTH-1:0] req_data3,
    output logic [3:0]       req_ready,
    output logic [3:0]       gnt,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic [1:0]       out_src,
    input  logic             out_ready
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_owner;
    logic [1:0]       w_ptr;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_last;
    logic [1:0]       r_out_src;

    logic [WIDTH-1:0] w_data [4];
    logic [3:0]       w_arb;
    logic             w_arb_found;
    logic [1:0]       w_scan;
    logic [3:0]       w_gnt;
    logic             w_can_load;
    logic [3:0]       w_ready;
    logic             w_accept;
    logic [1:0]       w_gidx;
    logic [WIDTH-1:0] w_sel_data;
    logic             w_sel_last;
    logic             w_sel_found;

    assign w_data[0] = req_data0;
    assign w_data[1] = req_data1;
    assign w_data[2] = req_data2;
    assign w_data[3] = req_data3;

    // Rotating scan: first valid request at or after ptr, wrapping mod 4.
    always_comb begin
        w_arb       = '0;
        w_arb_found = 1'b0;
        w_scan      = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            w_scan = w_ptr + 2'(k);
            if (!w_arb_found && req_valid[w_scan]) begin
                w_arb[w_scan] = 1'b1;
                w_arb_found   = 1'b1;
            end
        end
    end

    always_comb begin
        w_gnt = '0;
        if (!reset) begin
            if (r_state == BUSY)
                w_gnt = 4'b0001 << r_owner;
            else
                w_gnt = w_arb;
        end
    end

    assign w_can_load = !r_out_valid || out_ready;
    assign w_ready    = w_gnt & req_valid & {4{w_can_load}};
    assign w_accept   = |w_ready;

    // Priority select: lowest set select bit wins, so a one-hot grant picks exactly its source.
    always_comb begin
        w_sel_data  = '0;
        w_sel_last  = 1'b0;
        w_gidx      = '0;
        w_sel_found = 1'b0;
        for (int unsigned k = 0; k < 4; k++) begin
            if (!w_sel_found && w_gnt[k]) begin
                w_sel_data  = w_data[k];
                w_sel_last  = req_last[k];
                w_gidx      = 2'(k);
                w_sel_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            if (r_state == IDLE && !w_sel_last)
                w_state_nxt = BUSY;
            else if (r_state == BUSY && w_sel_last)
                w_state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_owner <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept && r_state == IDLE && !w_sel_last)
                r_owner <= w_gidx;
        end
    end

`ifdef SEL_ARB_RR_EN
    logic [1:0] r_ptr;

    always_ff @(posedge clk) begin
        if (reset)
            r_ptr <= '0;
        else if (w_accept && w_sel_last)
            r_ptr <= w_gidx + 2'd1;
    end

    assign w_ptr = r_ptr;
`else
    assign w_ptr = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_src   <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_sel_data;
            r_out_last  <= w_sel_last;
            r_out_src   <= w_gidx;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign gnt       = w_gnt;
    assign req_ready = w_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign out_src   = r_out_src;

endmodule

// File: tb/tb_sel_arb_32x4.sv
// Directed bench for sel_arb_32x4: vector table plus fairness and mid-packet reset sequences.
// Expectations follow SEL_ARB_RR_EN when it is defined for the bench too.
module tb_sel_arb_32x4;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [3:0]  req_last;
    logic [31:0] req_data0, req_data1, req_data2, req_data3;
    logic [3:0]  req_ready;
    logic [3:0]  gnt;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_last;
    logic [1:0]  out_src;
    logic        out_ready;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    sel_arb_32x4 #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_data0 (req_data0),
        .req_data1 (req_data1),
        .req_data2 (req_data2),
        .req_data3 (req_data3),
        .req_ready (req_ready),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  vld;
        logic [3:0]  lst;
        logic [31:0] base;
        logic        ordy;
        logic [3:0]  egnt;
        logic [3:0]  erdy;
        logic        eov;
        logic [31:0] edat;
        logic        elst;
        logic [1:0]  esrc;
    } vec_t;

    vec_t vecs [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endtask

    // Source k always presents base+k, so the selected source is visible in out_data.
    task automatic drive(input logic rst, input logic [3:0] vld, input logic [3:0] lst,
                         input logic [31:0] base, input logic ordy);
        reset     = rst;
        req_valid = vld;
        req_last  = lst;
        req_data0 = base;
        req_data1 = base + 32'd1;
        req_data2 = base + 32'd2;
        req_data3 = base + 32'd3;
        out_ready = ordy;
    endtask

    function automatic vec_t mk(input logic rst, input logic [3:0] vld, input logic [3:0] lst,
                                input logic [31:0] base, input logic ordy,
                                input logic [3:0] egnt, input logic [3:0] erdy, input logic eov,
                                input logic [31:0] edat, input logic elst, input logic [1:0] esrc);
        vec_t v;
        v.rst = rst; v.vld = vld; v.lst = lst; v.base = base; v.ordy = ordy;
        v.egnt = egnt; v.erdy = erdy; v.eov = eov; v.edat = edat; v.elst = elst; v.esrc = esrc;
        return v;
    endfunction

    initial begin
        int exp_src;
        int prev_src;

        // Registered expectations show the state produced by earlier rows' clock edges.
        //          rst vld      lst      base           ordy  gnt      rdy      ov  dat            lst  src
        vecs[0]  = mk(1, 4'b1111, 4'b0000, 32'h0,        1,    4'b0000, 4'b0000, 0, 32'h0,        0,   0);
        vecs[1]  = mk(1, 4'b1111, 4'b0000, 32'h0,        1,    4'b0000, 4'b0000, 0, 32'h0,        0,   0);
        vecs[2]  = mk(0, 4'b0000, 4'b0000, 32'h0,        1,    4'b0000, 4'b0000, 0, 32'h0,        0,   0);
        vecs[3]  = mk(0, 4'b0100, 4'b0100, 32'hA5A5_0000, 1,   4'b0100, 4'b0100, 0, 32'h0,        0,   0);
        vecs[4]  = mk(0, 4'b0000, 4'b0000, 32'h0,        1,    4'b0000, 4'b0000, 1, 32'hA5A5_0002, 1,  2);
        vecs[5]  = mk(0, 4'b0010, 4'b0000, 32'h10,       1,    4'b0010, 4'b0010, 0, 32'hA5A5_0002, 1,  2);
        vecs[6]  = mk(0, 4'b0011, 4'b0000, 32'h11,       1,    4'b0010, 4'b0010, 1, 32'h11,       0,   1);
        vecs[7]  = mk(0, 4'b0011, 4'b0010, 32'h12,       1,    4'b0010, 4'b0010, 1, 32'h12,       0,   1);
        vecs[8]  = mk(0, 4'b0001, 4'b0001, 32'h20,       1,    4'b0001, 4'b0001, 1, 32'h13,       1,   1);
        vecs[9]  = mk(0, 4'b0000, 4'b0000, 32'h0,        1,    4'b0000, 4'b0000, 1, 32'h20,       1,   0);
        vecs[10] = mk(0, 4'b0000, 4'b0000, 32'h0,        1,    4'b0000, 4'b0000, 0, 32'h20,       1,   0);
        vecs[11] = mk(0, 4'b1000, 4'b0000, 32'h30,       1,    4'b1000, 4'b1000, 0, 32'h20,       1,   0);
        vecs[12] = mk(0, 4'b1000, 4'b0000, 32'h40,       0,    4'b1000, 4'b0000, 1, 32'h33,       0,   3);
        vecs[13] = mk(0, 4'b1000, 4'b0000, 32'h40,       0,    4'b1000, 4'b0000, 1, 32'h33,       0,   3);
        vecs[14] = mk(0, 4'b1000, 4'b0000, 32'h40,       0,    4'b1000, 4'b0000, 1, 32'h33,       0,   3);
        vecs[15] = mk(0, 4'b1000, 4'b0000, 32'h40,       1,    4'b1000, 4'b1000, 1, 32'h33,       0,   3);
        vecs[16] = mk(0, 4'b0001, 4'b0001, 32'h50,       1,    4'b1000, 4'b0000, 1, 32'h43,       0,   3);
        vecs[17] = mk(0, 4'b1001, 4'b1000, 32'h60,       1,    4'b1000, 4'b1000, 0, 32'h43,       0,   3);
        vecs[18] = mk(0, 4'b0000, 4'b0000, 32'h0,        1,    4'b0000, 4'b0000, 1, 32'h63,       1,   3);
        vecs[19] = mk(0, 4'b0000, 4'b0000, 32'h0,        1,    4'b0000, 4'b0000, 0, 32'h63,       1,   3);

        drive(1'b1, 4'b1111, 4'b0000, 32'h0, 1'b1);
        @(posedge clk);

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].vld, vecs[i].lst, vecs[i].base, vecs[i].ordy);
            #1;
            chk($sformatf("v%0d_gnt", i),       32'(gnt),       32'(vecs[i].egnt));
            chk($sformatf("v%0d_ready", i),     32'(req_ready), 32'(vecs[i].erdy));
            chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].eov));
            chk($sformatf("v%0d_out_data", i),  out_data,       vecs[i].edat);
            chk($sformatf("v%0d_out_last", i),  32'(out_last),  32'(vecs[i].elst));
            chk($sformatf("v%0d_out_src", i),   32'(out_src),   32'(vecs[i].esrc));
        end

        // Fairness: every source keeps sending single-beat packets; ptr is 0 at this point.
        prev_src = -1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            drive(1'b0, 4'b1111, 4'b1111, 32'h70, 1'b1);
            #1;
`ifdef SEL_ARB_RR_EN
            exp_src = k % 4;
`else
            exp_src = 0;
`endif
            chk($sformatf("fair%0d_gnt", k), 32'(gnt), 32'(4'b0001 << exp_src));
            if (prev_src >= 0) begin
                chk($sformatf("fair%0d_out_src", k),  32'(out_src), 32'(prev_src));
                chk($sformatf("fair%0d_out_data", k), out_data,     32'h70 + 32'(prev_src));
                chk($sformatf("fair%0d_out_valid", k), 32'(out_valid), 32'd1);
            end
            prev_src = exp_src;
        end

        // Reset in the middle of a 2-beat src1 packet.
        @(negedge clk);
        drive(1'b0, 4'b0010, 4'b0000, 32'h80, 1'b1);
        #1;
        chk("mid_beat1_gnt", 32'(gnt), 32'(4'b0010));
        chk("mid_beat1_ready", 32'(req_ready), 32'(4'b0010));
        @(negedge clk);
        drive(1'b1, 4'b1111, 4'b0000, 32'h90, 1'b1);
        #1;
        chk("mid_rst_gnt", 32'(gnt), 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        chk("mid_rst_held_data", out_data, 32'h81);
        @(negedge clk);
        drive(1'b0, 4'b1111, 4'b1111, 32'hA0, 1'b0);
        #1;
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);
        chk("post_rst_out_data", out_data, 32'd0);
        chk("post_rst_gnt", 32'(gnt), 32'(4'b0001));
        chk("post_rst_ready", 32'(req_ready), 32'(4'b0001));
        @(negedge clk);
        drive(1'b0, 4'b0000, 4'b0000, 32'h0, 1'b1);
        #1;
        chk("post_rst_beat_src", 32'(out_src), 32'd0);
        chk("post_rst_beat_data", out_data, 32'hA0);
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/sel_arb_32x4.md
# sel_arb_32x4

Four-requester packet arbiter that shares one 32-bit output channel between four sources. It drives a one-hot grant vector of the same shape as the select input of the 32x4 priority select. The winner's data passes through that select into a single output register. A grant is held for a whole multi-beat packet; a round-robin policy can be compiled in.

## Interface
Parameters:
- WIDTH, 32, payload width of every source and of the output.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock for all state.
- reset  in  1  synchronous, active-high.
- req_valid  in  4  bit i: source i presents a beat.
- req_last  in  4  bit i: the beat from source i ends its packet.
- req_data0..req_data3  in  WIDTH each  source payloads.
- req_ready  out  4  bit i: the beat from source i is accepted this cycle.
- gnt  out  4  one-hot grant (all zero when no owner); connects to the select vector.
- out_valid  out  1  output register holds a beat.
- out_data  out  WIDTH  registered payload.
- out_last  out  1  registered last flag.
- out_src  out  2  index of the source of the registered beat.
- out_ready  in  1  downstream accepts the output beat.

## Operation
- State: IDLE or BUSY, plus a 2-bit owner and a 2-bit priority pointer ptr.
- IDLE:
  - gnt is the highest-priority set bit of req_valid; zero if none.
  - Order starts at ptr and wraps: ptr, ptr+1, ... mod 4.
- BUSY:
  - gnt = onehot(owner), whatever req_valid shows.
  - Other sources are not granted.
- Output register accepts a beat when (!out_valid || out_ready); call this "can_load".
- req_ready[i] = gnt[i] && req_valid[i] && can_load. Only the granted source ever sees ready.
- On an accepted beat:
  - out_data gets req_data of the granted source; out_last gets its req_last.
  - out_src gets the granted index; out_valid goes to 1.
- On out_ready with no new load: out_valid goes to 0. out_data, out_last and out_src hold their values.
- IDLE→BUSY when an accepted beat has last=0; owner is set to the granted index.
- IDLE stays IDLE when an accepted beat has last=1 (single-beat packet).
- BUSY→IDLE when an accepted beat has last=1.
- Packet completion is any accepted beat with last=1. On completion, ptr = granted index + 1 (mod 4), with the RR feature enabled.
- Owner drops req_valid mid-packet: grant is held, nothing is accepted, and there is no timeout.
- Requests from non-owners never affect the current packet.

## Timing
- Reset values:
  - out_valid=0, out_data=0, out_last=0, out_src=0.
  - state=IDLE, owner=0, ptr=0.
  - gnt=0 and req_ready=0 while reset is high.
- Latency:
  - Beat accepted in cycle N → out_valid=1 with that beat in N+1.
  - Arbitration is combinational in IDLE, so zero added cycles.
- Throughput is 1 beat/cycle while out_ready=1.
- Back-to-back packets: the cycle after a last beat is accepted, IDLE re-arbitrates with the updated ptr. There is no bubble between packets.
- Output held with out_ready=0: can_load=0, req_ready=0, and out_data is stable until accepted.
- Last accepted while another source requests in the same cycle: the new winner is granted the next cycle, never the same cycle.
- Reset mid-packet: state returns to IDLE, out_valid=0, and the beat held in the output register is discarded. Sources must restart their packets.

## Configuration
- SEL_ARB_RR_EN:
  - Defined: round-robin. ptr is updated on every packet completion as above.
  - Undefined: fixed priority with source 0 highest, then 1, 2, 3. This matches the priority-select order. ptr is constant 0 and has no update logic.

## Test plan
- Reset: assert reset for 2 cycles with req_valid=4'b1111 → req_ready=0, gnt=0, out_valid=0, out_data=0 throughout.
- Single beat:
  - Stimulus: src2 valid, last=1, data=32'hA5A5_0002, out_ready=1.
  - Response: req_ready[2]=1 in cycle N; out_valid=1, out_data=32'hA5A5_0002, out_src=2, out_last=1 in N+1; state stays IDLE.
- Packet lock:
  - Stimulus: src1 sends a 3-beat packet (32'h11,32'h12,32'h13). src0 asserts valid from beat 2 onward.
  - Response: gnt=4'b0010 for all 3 beats, req_ready[0]=0; src0 is granted the cycle after beat 3 is accepted.
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles during a packet from src3.
  - Response: out_data is held, req_ready[3]=0 for those cycles, no beat is lost or duplicated, and the order is preserved after release.
- Fairness with SEL_ARB_RR_EN defined:
  - Stimulus: all four sources continuously send single-beat packets.
  - Response: out_src sequence is 0,1,2,3,0,1... With the macro undefined, out_src=0 every beat.
- Reset mid-packet: reset after beat 1 of a 2-beat src1 packet → next cycle out_valid=0, state IDLE, ptr=0, gnt follows fresh arbitration.
